lfsr_sequence_generator: RTL and testbench

//   Parametrised serial test-pattern source that drives the bit-pattern detector.

---
 rtl/lfsr_sequence_generator.sv | 109 ++++++++++
 tb/tb_lfsr_sequence_generator.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lfsr_sequence_generator.sv
// Serial test-pattern source: Fibonacci LFSR or rotating pattern with
// seed load, zero-state recovery and sequence period measurement.
module lfsr_sequence_generator #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
    parameter logic [WIDTH-1:0] SEED  = 4'b1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    output logic             seq,
    output logic [WIDTH-1:0] state,
    output logic             period_done,
    output logic [WIDTH-1:0] period_len,
    output logic             lockup
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             lock_q, lock_d;

    logic [WIDTH-1:0] nxt;
    logic             fb;

    always_comb begin
        fb = ^(state_q & TAPS);
        // mode equals mode_q whenever a step is actually taken
        if (mode) begin
            nxt = {state_q[WIDTH-2:0], state_q[WIDTH-1]};
        end else begin
            nxt = {state_q[WIDTH-2:0], fb};
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        lock_d  = 1'b0;

        if (load) begin
            mode_d  = mode;
            cnt_d   = '0;
            if (!mode && load_val == '0) begin
                state_d = SEED;
                start_d = SEED;
                lock_d  = 1'b1;
            end else begin
                state_d = load_val;
                start_d = load_val;
            end
        end else if (mode != mode_q) begin
            mode_d  = mode;
            start_d = state_q;
            cnt_d   = '0;
        end else if (en && !mode && state_q == '0) begin
            state_d = SEED;
            start_d = SEED;
            cnt_d   = '0;
            lock_d  = 1'b1;
        end else if (en) begin
            state_d = nxt;
            if (nxt == start_q) begin
                done_d = 1'b1;
                len_d  = cnt_q + WIDTH'(1);
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEED;
            start_q <= SEED;
            cnt_q   <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            lock_q  <= lock_d;
        end
    end

    assign seq         = state_q[WIDTH-1];
    assign state       = state_q;
    assign period_done = done_q;
    assign period_len  = len_q;
    assign lockup      = lock_q;

endmodule

// File: tb/tb_lfsr_sequence_generator.sv
// Directed-vector bench for lfsr_sequence_generator with default
// parameters (x^4+x^3+1, seed 1000).
module tb_lfsr_sequence_generator;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       load;
    logic [3:0] load_val;
    logic       mode;
    logic       seq;
    logic [3:0] state;
    logic       period_done;
    logic [3:0] period_len;
    logic       lockup;

    int tests_run;
    int tests_failed;

    logic [3:0] lfsr_tab [16];
    logic [3:0] rot_tab  [4];

    lfsr_sequence_generator dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .load        (load),
        .load_val    (load_val),
        .mode        (mode),
        .seq         (seq),
        .state       (state),
        .period_done (period_done),
        .period_len  (period_len),
        .lockup      (lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        lfsr_tab = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                     4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111,
                     4'b1111, 4'b1110, 4'b1100, 4'b1000};
        rot_tab  = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};
        reset_n  = 1'b1;
        en       = 1'b0;
        load     = 1'b0;
        load_val = 4'b0000;
        mode     = 1'b0;
        #1;
        tick();
        do_reset();

        check("rst_state", 32'(state), 32'(4'b1000));
        check("rst_seq", 32'(seq), 32'(1'b1));
        check("rst_done", 32'(period_done), 32'(1'b0));
        check("rst_lock", 32'(lockup), 32'(1'b0));
        check("rst_len", 32'(period_len), 32'(4'd0));

        // Test 1: full default LFSR period
        en = 1'b1;
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("t1_state%0d", i), 32'(state), 32'(lfsr_tab[i]));
            check($sformatf("t1_seq%0d", i), 32'(seq), 32'(lfsr_tab[i][3]));
            check($sformatf("t1_done%0d", i), 32'(period_done),
                  32'(i == 15));
            check($sformatf("t1_lock%0d", i), 32'(lockup), 32'(1'b0));
        end
        check("t1_len", 32'(period_len), 32'(4'd15));

        // Test 6: async reset mid-sequence at 0110, period_len was 15
        for (int i = 1; i <= 6; i++) tick();
        check("t6_pre_state", 32'(state), 32'(4'b0110));
        check("t6_pre_len", 32'(period_len), 32'(4'd15));
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_state", 32'(state), 32'(4'b1000));
        check("t6_seq", 32'(seq), 32'(1'b1));
        check("t6_done", 32'(period_done), 32'(1'b0));
        check("t6_lock", 32'(lockup), 32'(1'b0));
        check("t6_len", 32'(period_len), 32'(4'd0));
        en = 1'b0;
        #1;
        reset_n = 1'b1;

        // Test 2: enable toggled 1,0,0,1
        tick();
        en = 1'b1;
        tick();
        check("t2_s1", 32'(state), 32'(4'b0001));
        en = 1'b0;
        tick();
        check("t2_s2", 32'(state), 32'(4'b0001));
        tick();
        check("t2_s3", 32'(state), 32'(4'b0001));
        check("t2_pulse", 32'({period_done, lockup}), 32'(2'b00));
        en = 1'b1;
        tick();
        check("t2_s4", 32'(state), 32'(4'b0010));
        check("t2_pulse2", 32'({period_done, lockup}), 32'(2'b00));
        en = 1'b0;

        // Test 3: rotate mode with loaded pattern
        load     = 1'b1;
        load_val = 4'b1011;
        mode     = 1'b1;
        tick();
        check("t3_load", 32'(state), 32'(4'b1011));
        load = 1'b0;
        en   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t3_state%0d", i), 32'(state), 32'(rot_tab[i]));
            check($sformatf("t3_seq%0d", i), 32'(seq), 32'(rot_tab[i][3]));
            check($sformatf("t3_done%0d", i), 32'(period_done),
                  32'(i == 3));
        end
        check("t3_len", 32'(period_len), 32'(4'd4));
        en = 1'b0;

        // Test 4: zero seed load in LFSR mode
        do_reset();
        load     = 1'b1;
        load_val = 4'b0000;
        mode     = 1'b0;
        tick();
        check("t4_state", 32'(state), 32'(4'b1000));
        check("t4_lock", 32'(lockup), 32'(1'b1));
        load = 1'b0;
        en   = 1'b1;
        tick();
        check("t4_resume", 32'(state), 32'(4'b0001));
        check("t4_lock_off", 32'(lockup), 32'(1'b0));
        en = 1'b0;

        // Test 5: zero in rotate mode, then switch to LFSR
        load     = 1'b1;
        load_val = 4'b0000;
        mode     = 1'b1;
        tick();
        check("t5_load", 32'(state), 32'(4'b0000));
        check("t5_nolock", 32'(lockup), 32'(1'b0));
        load = 1'b0;
        en   = 1'b1;
        tick();
        check("t5_rot0", 32'(state), 32'(4'b0000));
        check("t5_rot0_lock", 32'(lockup), 32'(1'b0));
        mode = 1'b0;
        tick();
        check("t5_switch", 32'(state), 32'(4'b0000));
        check("t5_switch_lock", 32'(lockup), 32'(1'b0));
        tick();
        check("t5_state", 32'(state), 32'(4'b1000));
        check("t5_lock", 32'(lockup), 32'(1'b1));
        tick();
        check("t5_next", 32'(state), 32'(4'b0001));
        check("t5_lock_off", 32'(lockup), 32'(1'b0));
        en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
